// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-Lite initiator turning a valid/ready command stream into
// pipelined word transfers, returning one in-order response per command.
// Two slots: AP (address phase, drives HADDR/HTRANS/HWRITE) and DP (data phase,
// drives HWDATA). A two-cycle ERROR aborts the beat waiting in AP, which is
// then replayed as NONSEQ once the erroring beat has been answered.
// Optional feature macro: AHB_MASTER_BUSY_EN -- a gap in a cmd_seq chain
// drives BUSY (next address) instead of IDLE, so the chain may resume as SEQ.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_seq,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // AHB-Lite master interface
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ERR    = 1'b1
  } state_t;

  state_t                r_state;

  // address-phase slot; r_ap_valid marks a real beat (also the replay beat in ERR)
  logic                  r_ap_valid;
  htrans_t               r_ap_trans;
  logic [ADDR_WIDTH-1:0] r_ap_addr;
  logic                  r_ap_write;
  logic                  r_ap_seq;
  logic [DATA_WIDTH-1:0] r_ap_wdata;

  // data-phase slot
  logic                  r_dp_valid;
  logic                  r_dp_write;
  logic [DATA_WIDTH-1:0] r_hwdata;

  // response registers
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_accept;
  htrans_t               w_new_trans;
  logic                  w_err_start;

  // A new command fits when AP is free now or is being handed to DP this edge.
  assign cmd_ready   = !HRESET && (r_state == ST_NORMAL) &&
                       (!r_ap_valid || (HREADY && !HRESP));
  assign w_accept    = cmd_valid && cmd_ready;
  // SEQ only when the bus was not IDLE in the cycle before this beat.
  assign w_new_trans = (cmd_seq && (r_ap_trans != TR_IDLE)) ? TR_SEQ : TR_NONSEQ;
  // First cycle of the two-cycle ERROR response.
  assign w_err_start = r_dp_valid && HRESP && !HREADY;

  // Pipeline, error state machine and response generation in one registered block.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in the block deliberately override earlier ones.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_NORMAL;
      r_ap_valid  <= 1'b0;
      r_ap_trans  <= TR_IDLE;
      r_ap_addr   <= '0;
      r_ap_write  <= 1'b0;
      r_ap_seq    <= 1'b0;
      r_ap_wdata  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_NORMAL: begin
          if (HREADY) begin
            // data phase completes, address phase advances into data phase
            if (r_dp_valid) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= HRESP;
              r_rsp_rdata <= (!r_dp_write && !HRESP) ? HRDATA : '0;
            end
            r_dp_valid <= r_ap_valid;
            r_dp_write <= r_ap_write;
            if (r_ap_valid) r_hwdata <= r_ap_wdata;
            if (!w_accept) begin
              r_ap_valid <= 1'b0;
`ifdef AHB_MASTER_BUSY_EN
              if (r_ap_valid && r_ap_seq) begin
                r_ap_trans <= TR_BUSY;
                r_ap_addr  <= r_ap_addr + ADDR_WIDTH'(4);
              end else if (r_ap_trans != TR_BUSY) begin
                r_ap_trans <= TR_IDLE;
              end
`else
              r_ap_trans <= TR_IDLE;
`endif
            end
          end
          if (w_accept) begin
            r_ap_valid <= 1'b1;
            r_ap_trans <= w_new_trans;
            r_ap_addr  <= cmd_addr;
            r_ap_write <= cmd_write;
            r_ap_seq   <= cmd_seq;
            r_ap_wdata <= cmd_wdata;
          end
          if (w_err_start) begin
            // abort the AP beat on the bus; it stays in the slot for replay
            r_ap_trans <= TR_IDLE;
            r_state    <= ST_ERR;
          end
        end
        ST_ERR: begin
          if (HREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_dp_valid  <= 1'b0;
            if (r_ap_valid) r_ap_trans <= TR_NONSEQ;
            r_state     <= ST_NORMAL;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  assign HADDR     = r_ap_addr;
  assign HTRANS    = r_ap_trans;
  assign HWRITE    = r_ap_write;
  assign HWDATA    = r_hwdata;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b001;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed bench for ahb_lite_master with a small AHB-Lite
// slave model (64-word memory, optional read wait states at 0x004, two-cycle
// ERROR for addresses >= 0x800). Bus activity and responses are logged per
// cycle and compared against hand-computed cycle offsets and data.
module tb_ahb_lite_master;

  localparam int LOGN = 1024;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_seq;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;

  ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_seq(cmd_seq), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // cycle counter: cycle k is the interval following the k-th rising edge
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [64];
  logic        s_active, s_write, s_err2, stall_en;
  logic [31:0] s_addr;
  int          s_wait;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (s_active) begin
      if (s_addr >= 32'h800) begin
        HRESP  = 1'b1;
        HREADY = s_err2;
      end else begin
        HREADY = (s_wait == 0);
        HRDATA = s_write ? 32'h0 : mem[s_addr[7:2]];
      end
    end
  end

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      s_active <= 1'b0;
      s_write  <= 1'b0;
      s_addr   <= '0;
      s_err2   <= 1'b0;
      s_wait   <= 0;
    end else if (HREADY) begin
      if (s_active && s_write && s_addr < 32'h800) mem[s_addr[7:2]] <= HWDATA;
      s_active <= HTRANS[1];
      s_addr   <= HADDR;
      s_write  <= HWRITE;
      s_err2   <= 1'b0;
      s_wait   <= (stall_en && HTRANS[1] && !HWRITE && HADDR == 32'h4) ? 2 : 0;
    end else begin
      if (s_wait > 0) s_wait <= s_wait - 1;
      if (s_active && s_addr >= 32'h800) s_err2 <= 1'b1;
    end
  end

  // ---------------- logging ----------------
  typedef struct {
    int          c;
    logic [31:0] d;
    logic        e;
  } rsp_t;
  rsp_t        rsp_q[$];
  logic [1:0]  tr_log [LOGN];
  logic [31:0] ad_log [LOGN];
  logic [31:0] wd_log [LOGN];

  always @(negedge HCLK) begin
    rsp_t r;
    if (rsp_valid) begin
      r.c = cyc;
      r.d = rsp_rdata;
      r.e = rsp_err;
      rsp_q.push_back(r);
    end
    if (cyc < LOGN) begin
      tr_log[cyc] = HTRANS;
      ad_log[cyc] = HADDR;
      wd_log[cyc] = HWDATA;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // present one command; returns the cycle in which it was accepted
  task automatic send(input logic wr, input logic sq, input logic [31:0] a,
                      input logic [31:0] d, output int acc);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_seq   = sq;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge HCLK);
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c, output logic [31:0] d, output logic e);
    rsp_t r;
    for (int i = 0; i < 50 && rsp_q.size() == 0; i++) begin
      @(negedge HCLK);
      #1;
    end
    if (rsp_q.size() == 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      c = -1000;
      d = 'x;
      e = 1'bx;
    end else begin
      r = rsp_q.pop_front();
      c = r.c;
      d = r.d;
      e = r.e;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] wdat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  int          exp_rc [4] = '{3, 6, 7, 8};
  int          acc [4];
  int          rc [4];
  logic [31:0] rd [4];
  logic        re [4];
  int          n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_seq   = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    stall_en  = 1'b0;
    repeat (2) @(negedge HCLK);

    // reset state
    check("rst_htrans", HTRANS, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwrite", HWRITE, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_cmd_ready", cmd_ready, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", rsp_err, 32'd0);
    HRESET = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 32'd1);
    check("hsize", HSIZE, 32'd2);
    check("hburst", HBURST, 32'd1);

    // single write then read back
    send(1'b1, 1'b0, 32'h4, 32'hDEAD_BEEF, acc[0]);
    wait_rsp(rc[0], rd[0], re[0]);
    check("t1_wr_lat", rc[0] - acc[0], 32'd3);
    check("t1_wr_rdata", rd[0], 32'h0);
    check("t1_wr_err", re[0], 32'd0);
    check("t1_wr_htrans", tr_log[acc[0]+1], 32'd2);
    check("t1_wr_haddr", ad_log[acc[0]+1], 32'h4);
    check("t1_wr_hwdata", wd_log[acc[0]+2], 32'hDEAD_BEEF);
    send(1'b0, 1'b0, 32'h4, 32'h0, acc[1]);
    wait_rsp(rc[1], rd[1], re[1]);
    check("t1_rd_lat", rc[1] - acc[1], 32'd3);
    check("t1_rd_rdata", rd[1], 32'hDEAD_BEEF);
    check("t1_rd_err", re[1], 32'd0);
    check("t1_rd_htrans", tr_log[acc[1]+1], 32'd2);

    // four back-to-back writes, then four back-to-back reads
    for (int i = 0; i < 4; i++) send(1'b1, i != 0, 32'(4*i), wdat[i], acc[i]);
    for (int i = 0; i < 4; i++) wait_rsp(rc[i], rd[i], re[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_wr_acc%0d", i), acc[i] - acc[0], 32'(i));
      check($sformatf("t2_wr_htrans%0d", i), tr_log[acc[0]+1+i], (i == 0) ? 32'd2 : 32'd3);
      check($sformatf("t2_wr_hwdata%0d", i), wd_log[acc[0]+2+i], wdat[i]);
      check($sformatf("t2_wr_lat%0d", i), rc[i] - acc[i], 32'd3);
    end
    for (int i = 0; i < 4; i++) send(1'b0, i != 0, 32'(4*i), 32'h0, acc[i]);
    for (int i = 0; i < 4; i++) wait_rsp(rc[i], rd[i], re[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rd_htrans%0d", i), tr_log[acc[0]+1+i], (i == 0) ? 32'd2 : 32'd3);
      check($sformatf("t2_rd_cycle%0d", i), rc[i] - acc[0], 32'(3 + i));
      check($sformatf("t2_rd_data%0d", i), rd[i], wdat[i]);
      check($sformatf("t2_rd_err%0d", i), re[i], 32'd0);
    end

    // two wait states on the second read
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, i != 0, 32'(4*i), 32'hFEED_0000 + 32'(i), acc[i]);
    for (int i = 0; i < 4; i++) wait_rsp(rc[i], rd[i], re[i]);
    stall_en = 1'b0;
    n = acc[0];
    check("t3_acc2", acc[2] - n, 32'd2);
    check("t3_acc3", acc[3] - n, 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_cycle%0d", i), rc[i] - n, 32'(exp_rc[i]));
      check($sformatf("t3_data%0d", i), rd[i], wdat[i]);
      check($sformatf("t3_err%0d", i), re[i], 32'd0);
    end
    for (int k = 3; k <= 5; k++) begin
      check($sformatf("t3_haddr_c%0d", k), ad_log[n+k], 32'h8);
      check($sformatf("t3_htrans_c%0d", k), tr_log[n+k], 32'd3);
      check($sformatf("t3_hwdata_c%0d", k), wd_log[n+k], 32'hFEED_0001);
    end

    // error on 0x804 with a pipelined read behind it
    send(1'b0, 1'b0, 32'h804, 32'h0, acc[0]);
    send(1'b0, 1'b0, 32'h008, 32'h0, acc[1]);
    wait_rsp(rc[0], rd[0], re[0]);
    wait_rsp(rc[1], rd[1], re[1]);
    n = acc[0];
    check("t4_acc1", acc[1] - n, 32'd1);
    check("t4_htrans_err1", tr_log[n+2], 32'd2);
    check("t4_htrans_idle", tr_log[n+3], 32'd0);
    check("t4_err_cycle", rc[0] - n, 32'd4);
    check("t4_err_flag", re[0], 32'd1);
    check("t4_err_rdata", rd[0], 32'h0);
    check("t4_replay_htrans", tr_log[n+4], 32'd2);
    check("t4_replay_haddr", ad_log[n+4], 32'h8);
    check("t4_replay_cycle", rc[1] - n, 32'd6);
    check("t4_replay_data", rd[1], wdat[2]);
    check("t4_replay_err", re[1], 32'd0);

    // chained writes with a one-cycle command gap
    send(1'b1, 1'b1, 32'h10, 32'hAAAA_0010, acc[0]);
    @(negedge HCLK);
    send(1'b1, 1'b1, 32'h14, 32'hAAAA_0014, acc[1]);
    wait_rsp(rc[0], rd[0], re[0]);
    wait_rsp(rc[1], rd[1], re[1]);
    n = acc[0];
    check("t5_acc1", acc[1] - n, 32'd2);
    check("t5_htrans0", tr_log[n+1], 32'd2);
    check("t5_haddr0", ad_log[n+1], 32'h10);
    check("t5_haddr2", ad_log[n+3], 32'h14);
`ifdef AHB_MASTER_BUSY_EN
    check("t5_htrans_gap", tr_log[n+2], 32'd1);
    check("t5_haddr_gap", ad_log[n+2], 32'h14);
    check("t5_htrans2", tr_log[n+3], 32'd3);
`else
    check("t5_htrans_gap", tr_log[n+2], 32'd0);
    check("t5_htrans2", tr_log[n+3], 32'd2);
`endif
    check("t5_lat0", rc[0] - acc[0], 32'd3);
    check("t5_lat1", rc[1] - acc[1], 32'd3);

    // reset in the middle of a burst
    send(1'b1, 1'b0, 32'h20, 32'hBBBB_0020, acc[0]);
    send(1'b1, 1'b1, 32'h24, 32'hBBBB_0024, acc[1]);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_seq   = 1'b1;
    cmd_addr  = 32'h28;
    cmd_wdata = 32'hBBBB_0028;
    HRESET    = 1'b1;
    #1;
    check("t6_htrans", HTRANS, 32'd0);
    check("t6_haddr", HADDR, 32'd0);
    check("t6_hwrite", HWRITE, 32'd0);
    check("t6_hwdata", HWDATA, 32'd0);
    check("t6_cmd_ready", cmd_ready, 32'd0);
    check("t6_rsp_valid", rsp_valid, 32'd0);
    repeat (3) @(negedge HCLK);
    cmd_valid = 1'b0;
    HRESET    = 1'b0;
    repeat (5) @(negedge HCLK);
    #1;
    check("t6_no_rsp", rsp_q.size(), 32'd0);
    send(1'b1, 1'b1, 32'h30, 32'hCCCC_0030, acc[0]);
    wait_rsp(rc[0], rd[0], re[0]);
    check("t6_new_htrans", tr_log[acc[0]+1], 32'd2);
    check("t6_new_haddr", ad_log[acc[0]+1], 32'h30);
    check("t6_new_lat", rc[0] - acc[0], 32'd3);
    check("t6_new_err", re[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite bus master (initiator) that converts a simple valid/ready command stream into pipelined AHB-Lite transfers. It returns one response per command, in order. It drives the shared AHB interface consumed by the slave-side decoder, memories and default slave, and supports back-to-back pipelining, slave wait states, the two-cycle error response and incrementing-burst sequencing. Word transfers only; HSIZE (3'b010) and HBURST (3'b001, INCR) are tied off at the top level.

## Interface
- ADDR_WIDTH, 32, HADDR and cmd_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA/cmd_wdata/rsp_rdata width
- HCLK  in  1  bus clock, all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge where valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_seq  in  1  beat continues previous burst (addr = previous+4, same direction)
- cmd_addr  in  ADDR_WIDTH  word-aligned byte address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transfer ended in ERROR
- HADDR  out  ADDR_WIDTH  address phase address
- HTRANS  out  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- HWRITE  out  1  address phase direction
- HWDATA  out  DATA_WIDTH  data phase write data
- HRDATA  in  DATA_WIDTH  read data from slave mux
- HREADY  in  1  transfer completion / wait state
- HRESP  in  1  0 OKAY, 1 ERROR

## Operation
- Two internal slots: address slot (AP) drives HADDR/HTRANS/HWRITE; data slot (DP) holds HWDATA and the direction of the beat in data phase. At most 2 beats outstanding.
- cmd_ready = state NORMAL and (AP empty or (HREADY=1 and HRESP=0)).
- Accepted command loads AP at that edge. HTRANS = SEQ if cmd_seq=1 and the previous beat issued was not followed by IDLE, else NONSEQ.
- On an edge with HREADY=1 and HRESP=0: DP completes (response generated), AP moves to DP (HWDATA loaded from the AP's wdata), AP reloads or empties (HTRANS=IDLE).
- HREADY=0: all bus outputs hold.
- State machine NORMAL/ERR:
  - In NORMAL, DP with HRESP=1 and HREADY=0: next edge forces HTRANS=IDLE, the AP beat is retained as a replay beat, go to ERR.
  - In ERR, first edge with HREADY=1 completes the DP beat with rsp_err=1 (regardless of HRESP), return to NORMAL.
  - The replay beat is reissued as NONSEQ on the following cycle, before any new command.
- Responses are strictly in command order. A write response has rsp_rdata=0. A read captures HRDATA at the completing edge.
- Address increment/overflow is not checked; HADDR is the user address verbatim.

## Timing
- Reset (async assert, sync deassert at HCLK): HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, cmd_ready=0 while HRESET=1 then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state NORMAL, slots empty.
- Zero-wait latency: accept at edge E0 → address phase E0–E1 → data phase E1–E2 → rsp_valid high the cycle after E2 (3 cycles).
- Throughput: one beat per cycle with HREADY=1 continuously.
- Each wait cycle delays every later event by one cycle.
- Error: cycle 1 (HRESP=1, HREADY=0) → next cycle HTRANS=IDLE; response issued after HREADY=1; replay NONSEQ the cycle after.
- Reset mid-operation: in-flight beats are discarded, no responses.

## Configuration
- AHB_MASTER_BUSY_EN defined: after a beat issued with cmd_seq chaining, if no command is pending, HTRANS=BUSY and HADDR = last address+4, HWRITE unchanged. The next command goes out as SEQ (cmd_seq=1) or NONSEQ (cmd_seq=0).
- Undefined: the gap drives IDLE, and the next beat is always NONSEQ regardless of cmd_seq.

## Test plan
- Write 0xDEADBEEF to 0x004, then read 0x004 → HTRANS NONSEQ both; read rsp_rdata=0xDEADBEEF, rsp_err=0, 3-cycle latency each.
- Four back-to-back writes 0x000–0x00C (cmd_seq=0,1,1,1), then four reads → HTRANS 10,11,11,11; one beat per cycle; 4 in-order responses matching data.
- Slave holds HREADY=0 for 2 cycles on the second read → HADDR/HTRANS/HWDATA stable those cycles; responses shift by 2 cycles, data intact.
- Read 0x804 (unmapped) followed by pipelined read 0x008 → HTRANS=IDLE after first error cycle; rsp_err=1 for 0x804; 0x008 reissued NONSEQ and returns correct data.
- With AHB_MASTER_BUSY_EN: SEQ write 0x010, 1-cycle command gap, SEQ write 0x014 → HTRANS 10,01,11 with HADDR 0x010,0x014,0x014. Without the macro: HTRANS 10,00,10.
- Assert HRESET during a 4-beat burst → all outputs at reset values immediately; no rsp_valid for in-flight beats; a new command after release issues NONSEQ.
